// File: rtl/roi_pkg.sv
// Shared types, register offsets and helpers for the ROI APB register file.
package roi_pkg;

    localparam int unsigned APB_DATA_WIDTH = 32;
    localparam int unsigned COORD_WIDTH    = 16;
    localparam int unsigned MAX_ROI        = 16;
    localparam int unsigned ROI_IDX_W      = 4;

    localparam int unsigned ROI_REGION_END = 32'h100;
    localparam int unsigned REG_CTRL       = 32'h100;
    localparam int unsigned REG_STATUS     = 32'h104;
    localparam int unsigned REG_COMMIT     = 32'h108;

    typedef struct packed {
        logic [COORD_WIDTH-1:0] y;
        logic [COORD_WIDTH-1:0] x;
    } roi_pt_t;

    typedef struct packed {
        roi_pt_t xy0;
        roi_pt_t xy1;
        logic    en;
    } roi_rect_t;

    typedef enum logic {
        IDLE,
        RESP
    } apb_state_e;

    typedef enum logic [2:0] {
        SEL_NONE,
        SEL_XY0,
        SEL_XY1,
        SEL_CTRL,
        SEL_STATUS,
        SEL_COMMIT
    } reg_sel_e;

    // STATUS bits that software may clear: err and the per-ROI invalid flags.
    function automatic logic [APB_DATA_WIDTH-1:0] status_w1c_mask(input int unsigned n_roi);
        logic [APB_DATA_WIDTH-1:0] m;
        m    = '0;
        m[1] = 1'b1;
        for (int unsigned i = 0; i < MAX_ROI; i++) begin
            if (i < n_roi) m[16+i] = 1'b1;
        end
        return m;
    endfunction

endpackage

// File: rtl/roi_bank.sv
// Storage for one ROI channel: shadow/active rectangles, validation and commit.
// ROI_SHADOW_EN selects double buffering; otherwise writes land in active directly.
module roi_bank
    import roi_pkg::*;
(
    input  logic                      clk_i,
    input  logic                      arst_i,
    input  logic                      wr_xy0_i,
    input  logic                      wr_xy1_i,
    input  logic                      wr_en_i,
    input  logic [APB_DATA_WIDTH-1:0] wdata_i,
    input  logic                      en_i,
    input  logic                      commit_i,
    output roi_rect_t                 shadow_o,
    output roi_rect_t                 active_o,
    output logic                      invalid_c_o
);

    roi_rect_t active_q, active_d;

`ifdef ROI_SHADOW_EN
    roi_rect_t shadow_q, shadow_d;

    always_comb begin
        shadow_d = shadow_q;
        if (wr_xy0_i) shadow_d.xy0 = roi_pt_t'(wdata_i);
        if (wr_xy1_i) shadow_d.xy1 = roi_pt_t'(wdata_i);
        if (wr_en_i)  shadow_d.en  = en_i;
    end

    assign invalid_c_o = (shadow_q.xy0.x > shadow_q.xy1.x) || (shadow_q.xy0.y > shadow_q.xy1.y);

    // Commit copies the pre-write shadow; an inverted rectangle only drops the enable.
    always_comb begin
        active_d = active_q;
        if (commit_i) begin
            if (invalid_c_o) active_d.en = 1'b0;
            else             active_d    = shadow_q;
        end
    end

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) shadow_q <= '0;
        else        shadow_q <= shadow_d;
    end

    assign shadow_o = shadow_q;
`else
    logic unused_commit;

    always_comb begin
        active_d = active_q;
        if (wr_xy0_i) active_d.xy0 = roi_pt_t'(wdata_i);
        if (wr_xy1_i) active_d.xy1 = roi_pt_t'(wdata_i);
        if (wr_en_i)  active_d.en  = en_i;
    end

    assign invalid_c_o   = 1'b0;
    assign unused_commit = commit_i;
    assign shadow_o      = active_q;
`endif

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) active_q <= '0;
        else        active_q <= active_d;
    end

    assign active_o = active_q;

endmodule

// File: rtl/roi_apb_regfile.sv
// APB3 slave for multi-ROI configuration: FSM, decode, status/pending and ROI banks.
// ROI_SHADOW_EN enables shadow/active double buffering with frame-boundary commit.
module roi_apb_regfile
    import roi_pkg::*;
#(
    parameter int unsigned NUM_ROI        = 4,
    parameter int unsigned APB_ADDR_WIDTH = 12
) (
    input  logic                      clk_i,
    input  logic                      arst_i,
    input  logic                      apb_psel_i,
    input  logic                      apb_penable_i,
    input  logic                      apb_pwrite_i,
    input  logic [APB_ADDR_WIDTH-1:0] apb_paddr_i,
    input  logic [APB_DATA_WIDTH-1:0] apb_pwdata_i,
    output logic [APB_DATA_WIDTH-1:0] apb_prdata_o,
    output logic                      apb_pready_o,
    output logic                      apb_pslverr_o,
    input  logic                      frame_start_i,
    output logic [NUM_ROI*32-1:0]     roi_xy0_o,
    output logic [NUM_ROI*32-1:0]     roi_xy1_o,
    output logic [NUM_ROI-1:0]        roi_en_o,
    output logic                      commit_done_o
);

    localparam logic [APB_DATA_WIDTH-1:0] W1C_MASK = status_w1c_mask(NUM_ROI);

    apb_state_e                state_q, state_d;
    logic                      pready_q, pready_d;
    logic                      pslverr_q, pslverr_d;
    logic [APB_DATA_WIDTH-1:0] prdata_q, prdata_d;
    logic                      capture_c;

    reg_sel_e                  sel_q;
    logic [ROI_IDX_W-1:0]      idx_q;
    logic                      write_q;
    logic [APB_DATA_WIDTH-1:0] wdata_q;

    logic                      pending_q, pending_d;
    logic                      err_q, err_d;
    logic [NUM_ROI-1:0]        flag_q, flag_d;
    logic                      commit_done_q;

    reg_sel_e                  dec_sel;
    logic [ROI_IDX_W-1:0]      dec_idx;
    logic                      status_bad_c;
    logic [APB_DATA_WIDTH-1:0] rd_c;

    logic                      apply_c;
    logic                      commit_c;
    logic [NUM_ROI-1:0]        wr_xy0_c, wr_xy1_c, invalid_c, shadow_en;
    logic                      wr_ctrl_c;
    roi_rect_t                 shadow [NUM_ROI];
    roi_rect_t                 active [NUM_ROI];

    // Address decode of the live access-phase address.
    always_comb begin
        dec_sel = SEL_NONE;
        dec_idx = apb_paddr_i[7:4];
        if (apb_paddr_i[1:0] == 2'b00) begin
            if (apb_paddr_i < APB_ADDR_WIDTH'(ROI_REGION_END)) begin
                if (32'(dec_idx) < NUM_ROI) begin
                    if (apb_paddr_i[3:2] == 2'd0)      dec_sel = SEL_XY0;
                    else if (apb_paddr_i[3:2] == 2'd1) dec_sel = SEL_XY1;
                end
            end else if (apb_paddr_i == APB_ADDR_WIDTH'(REG_CTRL)) begin
                dec_sel = SEL_CTRL;
            end else if (apb_paddr_i == APB_ADDR_WIDTH'(REG_STATUS)) begin
                dec_sel = SEL_STATUS;
            end else if (apb_paddr_i == APB_ADDR_WIDTH'(REG_COMMIT)) begin
                dec_sel = SEL_COMMIT;
            end
        end
    end

    assign status_bad_c = (dec_sel == SEL_STATUS) && apb_pwrite_i && ((apb_pwdata_i & ~W1C_MASK) != '0);

    always_comb begin
        rd_c = '0;
        case (dec_sel)
            SEL_XY0: begin
                for (int unsigned i = 0; i < NUM_ROI; i++) begin
                    if (dec_idx == ROI_IDX_W'(i)) rd_c = shadow[i].xy0;
                end
            end
            SEL_XY1: begin
                for (int unsigned i = 0; i < NUM_ROI; i++) begin
                    if (dec_idx == ROI_IDX_W'(i)) rd_c = shadow[i].xy1;
                end
            end
            SEL_CTRL: rd_c[NUM_ROI-1:0] = shadow_en;
            SEL_STATUS: begin
                rd_c[0]            = pending_q;
                rd_c[1]            = err_q;
                rd_c[16 +: NUM_ROI] = flag_q;
            end
            default: rd_c = '0;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        pready_d  = 1'b0;
        pslverr_d = 1'b0;
        prdata_d  = '0;
        capture_c = 1'b0;
        case (state_q)
            IDLE: begin
                if (apb_psel_i && apb_penable_i) begin
                    state_d   = RESP;
                    pready_d  = 1'b1;
                    capture_c = 1'b1;
                    pslverr_d = (dec_sel == SEL_NONE) || status_bad_c;
                    if (!apb_pwrite_i && (dec_sel != SEL_NONE)) prdata_d = rd_c;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Writes take effect on the edge that leaves RESP, from the captured access.
    assign apply_c   = (state_q == RESP) && write_q;
    assign wr_ctrl_c = apply_c && (sel_q == SEL_CTRL);

    always_comb begin
        for (int unsigned i = 0; i < NUM_ROI; i++) begin
            wr_xy0_c[i] = apply_c && (sel_q == SEL_XY0) && (idx_q == ROI_IDX_W'(i));
            wr_xy1_c[i] = apply_c && (sel_q == SEL_XY1) && (idx_q == ROI_IDX_W'(i));
        end
    end

`ifdef ROI_SHADOW_EN
    assign commit_c = frame_start_i && pending_q;
`else
    logic unused_frame;
    assign commit_c     = 1'b0;
    assign unused_frame = frame_start_i;
`endif

    // Commit flag-set wins over a concurrent W1C; a concurrent COMMIT write re-arms pending.
    always_comb begin
        pending_d = pending_q;
        err_d     = err_q;
        flag_d    = flag_q;
        if (apply_c && (sel_q == SEL_STATUS)) begin
            err_d  = err_q & ~wdata_q[1];
            flag_d = flag_q & ~wdata_q[16 +: NUM_ROI];
        end
        if (commit_c) begin
            pending_d = 1'b0;
            flag_d    = flag_d | invalid_c;
            err_d     = err_d | (|invalid_c);
        end
`ifdef ROI_SHADOW_EN
        if (apply_c && (sel_q == SEL_COMMIT) && wdata_q[0]) pending_d = 1'b1;
`endif
    end

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            state_q       <= IDLE;
            pready_q      <= 1'b0;
            pslverr_q     <= 1'b0;
            prdata_q      <= '0;
            sel_q         <= SEL_NONE;
            idx_q         <= '0;
            write_q       <= 1'b0;
            wdata_q       <= '0;
            pending_q     <= 1'b0;
            err_q         <= 1'b0;
            flag_q        <= '0;
            commit_done_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            pready_q      <= pready_d;
            pslverr_q     <= pslverr_d;
            prdata_q      <= prdata_d;
            pending_q     <= pending_d;
            err_q         <= err_d;
            flag_q        <= flag_d;
            commit_done_q <= commit_c;
            if (capture_c) begin
                sel_q   <= dec_sel;
                idx_q   <= dec_idx;
                write_q <= apb_pwrite_i;
                wdata_q <= apb_pwdata_i;
            end
        end
    end

    for (genvar g = 0; g < NUM_ROI; g++) begin : g_roi
        roi_bank u_bank (
            .clk_i       (clk_i),
            .arst_i      (arst_i),
            .wr_xy0_i    (wr_xy0_c[g]),
            .wr_xy1_i    (wr_xy1_c[g]),
            .wr_en_i     (wr_ctrl_c),
            .wdata_i     (wdata_q),
            .en_i        (wdata_q[g]),
            .commit_i    (commit_c),
            .shadow_o    (shadow[g]),
            .active_o    (active[g]),
            .invalid_c_o (invalid_c[g])
        );
        assign roi_xy0_o[32*g +: 32] = active[g].xy0;
        assign roi_xy1_o[32*g +: 32] = active[g].xy1;
        assign roi_en_o[g]           = active[g].en;
        assign shadow_en[g]          = shadow[g].en;
    end

    assign apb_pready_o  = pready_q;
    assign apb_pslverr_o = pslverr_q;
    assign apb_prdata_o  = prdata_q;
    assign commit_done_o = commit_done_q;

endmodule

// File: tb/tb_roi_apb_regfile.sv
// Directed self-checking bench for roi_apb_regfile (shadowed or direct build).
module tb_roi_apb_regfile;

    localparam int unsigned NUM_ROI = 4;

    logic                   clk_i = 1'b0;
    logic                   arst_i;
    logic                   apb_psel_i, apb_penable_i, apb_pwrite_i;
    logic [11:0]            apb_paddr_i;
    logic [31:0]            apb_pwdata_i;
    logic [31:0]            apb_prdata_o;
    logic                   apb_pready_o, apb_pslverr_o;
    logic                   frame_start_i;
    logic [NUM_ROI*32-1:0]  roi_xy0_o, roi_xy1_o;
    logic [NUM_ROI-1:0]     roi_en_o;
    logic                   commit_done_o;

    int passed = 0;
    int total  = 0;

    roi_apb_regfile #(.NUM_ROI(NUM_ROI), .APB_ADDR_WIDTH(12)) dut (
        .clk_i         (clk_i),
        .arst_i        (arst_i),
        .apb_psel_i    (apb_psel_i),
        .apb_penable_i (apb_penable_i),
        .apb_pwrite_i  (apb_pwrite_i),
        .apb_paddr_i   (apb_paddr_i),
        .apb_pwdata_i  (apb_pwdata_i),
        .apb_prdata_o  (apb_prdata_o),
        .apb_pready_o  (apb_pready_o),
        .apb_pslverr_o (apb_pslverr_o),
        .frame_start_i (frame_start_i),
        .roi_xy0_o     (roi_xy0_o),
        .roi_xy1_o     (roi_xy1_o),
        .roi_en_o      (roi_en_o),
        .commit_done_o (commit_done_o)
    );

    always #5 clk_i = ~clk_i;

    // One APB transfer; lat counts sampled cycles from the setup cycle (2 = pready at T+2).
    // With chain=1 the bus is left asserted so the next call runs back-to-back.
    task automatic apb_xfer(input logic [11:0] addr, input logic wr, input logic [31:0] wd,
                            input bit chain, output logic [31:0] rd, output logic err,
                            output int lat);
        @(posedge clk_i); #1;
        apb_psel_i = 1'b1; apb_penable_i = 1'b0; apb_pwrite_i = wr;
        apb_paddr_i = addr; apb_pwdata_i = wd;
        @(posedge clk_i); #1;
        apb_penable_i = 1'b1;
        lat = 1;
        @(negedge clk_i);
        while (!apb_pready_o && lat < 8) begin
            @(negedge clk_i);
            lat++;
        end
        rd  = apb_prdata_o;
        err = apb_pslverr_o;
        if (!chain) begin
            @(posedge clk_i); #1;
            apb_psel_i = 1'b0; apb_penable_i = 1'b0;
        end
    endtask

    task automatic frame_pulse();
        @(posedge clk_i); #1 frame_start_i = 1'b1;
        @(posedge clk_i); #1 frame_start_i = 1'b0;
        @(negedge clk_i);
    endtask

    task automatic test_reset();
        logic [31:0] rd; logic err; int lat;
        arst_i = 1'b1; apb_psel_i = 1'b0; apb_penable_i = 1'b0; apb_pwrite_i = 1'b0;
        apb_paddr_i = '0; apb_pwdata_i = '0; frame_start_i = 1'b0;
        repeat (3) @(posedge clk_i);
        #1 arst_i = 1'b0;
        @(negedge clk_i);
        total++; if (roi_xy0_o !== '0 || roi_xy1_o !== '0) $display("FAIL reset_xy: xy0=%h xy1=%h want 0", roi_xy0_o, roi_xy1_o); else passed++;
        total++; if (roi_en_o !== 4'h0 || commit_done_o !== 1'b0) $display("FAIL reset_en: en=%b done=%b want 0", roi_en_o, commit_done_o); else passed++;
        total++; if ({apb_pready_o, apb_pslverr_o, apb_prdata_o} !== 34'h0) $display("FAIL reset_apb: pready=%b slverr=%b prdata=%h want 0", apb_pready_o, apb_pslverr_o, apb_prdata_o); else passed++;
        apb_xfer(12'h104, 1'b0, 32'h0, 1'b0, rd, err, lat);
        total++; if (lat !== 2) $display("FAIL status_latency: got %0d want 2", lat); else passed++;
        total++; if (rd !== 32'h0 || err !== 1'b0) $display("FAIL status_read: prdata=%h slverr=%b want 0/0", rd, err); else passed++;
    endtask

`ifdef ROI_SHADOW_EN
    task automatic test_commit();
        logic [31:0] rd; logic err; int lat;
        apb_xfer(12'h010, 1'b1, 32'h0010_0020, 1'b0, rd, err, lat);
        apb_xfer(12'h014, 1'b1, 32'h0040_0080, 1'b0, rd, err, lat);
        apb_xfer(12'h100, 1'b1, 32'h0000_0002, 1'b0, rd, err, lat);
        apb_xfer(12'h108, 1'b1, 32'h0000_0001, 1'b0, rd, err, lat);
        apb_xfer(12'h010, 1'b0, 32'h0, 1'b0, rd, err, lat);
        total++; if (rd !== 32'h0010_0020) $display("FAIL shadow_readback: got %h want 00100020", rd); else passed++;
        total++; if (roi_xy0_o[63:32] !== 32'h0 || roi_en_o !== 4'h0) $display("FAIL precommit_active: xy0=%h en=%b want 0", roi_xy0_o[63:32], roi_en_o); else passed++;
        apb_xfer(12'h104, 1'b0, 32'h0, 1'b0, rd, err, lat);
        total++; if (rd !== 32'h1) $display("FAIL pending_set: got %h want 00000001", rd); else passed++;
        frame_pulse();
        total++; if (roi_xy0_o[63:32] !== 32'h0010_0020 || roi_xy1_o[63:32] !== 32'h0040_0080) $display("FAIL commit_xy: xy0=%h xy1=%h want 00100020/00400080", roi_xy0_o[63:32], roi_xy1_o[63:32]); else passed++;
        total++; if (roi_en_o !== 4'b0010 || commit_done_o !== 1'b1) $display("FAIL commit_en: en=%b done=%b want 0010/1", roi_en_o, commit_done_o); else passed++;
        @(negedge clk_i);
        total++; if (commit_done_o !== 1'b0) $display("FAIL commit_done_pulse: got %b want 0", commit_done_o); else passed++;
        frame_pulse();
        total++; if (commit_done_o !== 1'b0) $display("FAIL idle_frame: done=%b want 0", commit_done_o); else passed++;
    endtask

    task automatic test_commit_collision();
        logic [31:0] rd; logic err; int lat;
        apb_xfer(12'h020, 1'b1, 32'h0002_0003, 1'b0, rd, err, lat);
        apb_xfer(12'h024, 1'b1, 32'h0004_0005, 1'b0, rd, err, lat);
        apb_xfer(12'h100, 1'b1, 32'h0000_0006, 1'b0, rd, err, lat);
        apb_xfer(12'h108, 1'b1, 32'h0000_0001, 1'b1, rd, err, lat);
        frame_start_i = 1'b1;
        @(posedge clk_i); #1;
        frame_start_i = 1'b0; apb_psel_i = 1'b0; apb_penable_i = 1'b0;
        @(negedge clk_i);
        total++; if (roi_en_o !== 4'b0010 || commit_done_o !== 1'b0 || roi_xy0_o[95:64] !== 32'h0) $display("FAIL collide_nocopy: en=%b done=%b xy0=%h want 0010/0/0", roi_en_o, commit_done_o, roi_xy0_o[95:64]); else passed++;
        apb_xfer(12'h104, 1'b0, 32'h0, 1'b0, rd, err, lat);
        total++; if (rd !== 32'h1) $display("FAIL collide_pending: got %h want 00000001", rd); else passed++;
        frame_pulse();
        total++; if (roi_en_o !== 4'b0110 || roi_xy0_o[95:64] !== 32'h0002_0003 || commit_done_o !== 1'b1) $display("FAIL collide_copy: en=%b xy0=%h done=%b want 0110/00020003/1", roi_en_o, roi_xy0_o[95:64], commit_done_o); else passed++;
    endtask

    task automatic test_invalid();
        logic [31:0] rd; logic err; int lat;
        apb_xfer(12'h000, 1'b1, 32'h0000_0100, 1'b0, rd, err, lat);
        apb_xfer(12'h004, 1'b1, 32'h0000_0010, 1'b0, rd, err, lat);
        apb_xfer(12'h100, 1'b1, 32'h0000_0007, 1'b0, rd, err, lat);
        apb_xfer(12'h108, 1'b1, 32'h0000_0001, 1'b0, rd, err, lat);
        frame_pulse();
        total++; if (roi_en_o !== 4'b0110 || roi_xy0_o[31:0] !== 32'h0) $display("FAIL invalid_active: en=%b xy0=%h want 0110/0", roi_en_o, roi_xy0_o[31:0]); else passed++;
        apb_xfer(12'h104, 1'b0, 32'h0, 1'b0, rd, err, lat);
        total++; if (rd !== 32'h0001_0002) $display("FAIL invalid_status: got %h want 00010002", rd); else passed++;
        apb_xfer(12'h104, 1'b1, 32'h0001_0002, 1'b0, rd, err, lat);
        total++; if (err !== 1'b0) $display("FAIL w1c_slverr: got %b want 0", err); else passed++;
        apb_xfer(12'h104, 1'b0, 32'h0, 1'b0, rd, err, lat);
        total++; if (rd !== 32'h0) $display("FAIL w1c_clear: got %h want 0", rd); else passed++;
    endtask
`else
    task automatic test_direct();
        logic [31:0] rd; logic err; int lat;
        apb_xfer(12'h024, 1'b1, 32'h1234_5678, 1'b0, rd, err, lat);
        @(negedge clk_i);
        total++; if (roi_xy1_o[95:64] !== 32'h1234_5678) $display("FAIL direct_xy1: got %h want 12345678", roi_xy1_o[95:64]); else passed++;
        apb_xfer(12'h024, 1'b0, 32'h0, 1'b0, rd, err, lat);
        total++; if (rd !== 32'h1234_5678) $display("FAIL direct_readback: got %h want 12345678", rd); else passed++;
        frame_pulse();
        total++; if (commit_done_o !== 1'b0 || roi_xy1_o[95:64] !== 32'h1234_5678) $display("FAIL direct_frame: done=%b xy1=%h want 0/12345678", commit_done_o, roi_xy1_o[95:64]); else passed++;
        apb_xfer(12'h100, 1'b1, 32'hFFFF_FFF5, 1'b0, rd, err, lat);
        @(negedge clk_i);
        total++; if (roi_en_o !== 4'b0101) $display("FAIL direct_en: got %b want 0101", roi_en_o); else passed++;
        apb_xfer(12'h100, 1'b0, 32'h0, 1'b0, rd, err, lat);
        total++; if (rd !== 32'h5) $display("FAIL ctrl_readback: got %h want 00000005", rd); else passed++;
        apb_xfer(12'h108, 1'b1, 32'h1, 1'b0, rd, err, lat);
        total++; if (err !== 1'b0) $display("FAIL commit_accept: slverr=%b want 0", err); else passed++;
        apb_xfer(12'h000, 1'b1, 32'h0000_0100, 1'b0, rd, err, lat);
        apb_xfer(12'h004, 1'b1, 32'h0000_0010, 1'b0, rd, err, lat);
        frame_pulse();
        total++; if (roi_en_o[0] !== 1'b1 || roi_xy0_o[31:0] !== 32'h0000_0100) $display("FAIL direct_noval: en0=%b xy0=%h want 1/00000100", roi_en_o[0], roi_xy0_o[31:0]); else passed++;
        apb_xfer(12'h104, 1'b0, 32'h0, 1'b0, rd, err, lat);
        total++; if (rd !== 32'h0) $display("FAIL direct_status: got %h want 0", rd); else passed++;
    endtask
`endif

    task automatic test_errors();
        logic [31:0] rd; logic err; int lat;
        logic [NUM_ROI*32-1:0] xy0_before;
        xy0_before = roi_xy0_o;
        apb_xfer(12'h0FC, 1'b0, 32'h0, 1'b0, rd, err, lat);
        total++; if (err !== 1'b1 || rd !== 32'h0) $display("FAIL err_unmapped: slverr=%b prdata=%h want 1/0", err, rd); else passed++;
        apb_xfer(12'h002, 1'b0, 32'h0, 1'b0, rd, err, lat);
        total++; if (err !== 1'b1 || rd !== 32'h0) $display("FAIL err_unaligned: slverr=%b prdata=%h want 1/0", err, rd); else passed++;
        apb_xfer(12'h040, 1'b1, 32'hDEAD_BEEF, 1'b0, rd, err, lat);
        total++; if (err !== 1'b1 || lat !== 2) $display("FAIL err_roi_range: slverr=%b lat=%0d want 1/2", err, lat); else passed++;
        apb_xfer(12'h000, 1'b0, 32'h0, 1'b0, rd, err, lat);
        total++; if (rd !== 32'h0000_0100 || err !== 1'b0) $display("FAIL err_nochange: got %h/%b want 00000100/0", rd, err); else passed++;
        total++; if (roi_xy0_o !== xy0_before) $display("FAIL err_active: got %h want %h", roi_xy0_o, xy0_before); else passed++;
        apb_xfer(12'h104, 1'b1, 32'h0000_0001, 1'b0, rd, err, lat);
        total++; if (err !== 1'b1) $display("FAIL err_status_ro: slverr=%b want 1", err); else passed++;
        apb_xfer(12'h10C, 1'b1, 32'h1, 1'b0, rd, err, lat);
        total++; if (err !== 1'b1) $display("FAIL err_past_commit: slverr=%b want 1", err); else passed++;
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd; logic err; int lat;
        apb_xfer(12'h030, 1'b1, 32'h0A0B_0C0D, 1'b1, rd, err, lat);
        total++; if (lat !== 2 || err !== 1'b0) $display("FAIL b2b_write: lat=%0d slverr=%b want 2/0", lat, err); else passed++;
        apb_xfer(12'h030, 1'b0, 32'h0, 1'b1, rd, err, lat);
        total++; if (lat !== 2 || rd !== 32'h0A0B_0C0D) $display("FAIL b2b_read: lat=%0d prdata=%h want 2/0a0b0c0d", lat, rd); else passed++;
        apb_xfer(12'h034, 1'b1, 32'h0F0E_0D0C, 1'b1, rd, err, lat);
        apb_xfer(12'h034, 1'b0, 32'h0, 1'b0, rd, err, lat);
        total++; if (lat !== 2 || rd !== 32'h0F0E_0D0C) $display("FAIL b2b_read2: lat=%0d prdata=%h want 2/0f0e0d0c", lat, rd); else passed++;
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd; logic err; int lat;
        @(posedge clk_i); #1;
        apb_psel_i = 1'b1; apb_penable_i = 1'b0; apb_pwrite_i = 1'b1;
        apb_paddr_i = 12'h100; apb_pwdata_i = 32'hF;
        @(posedge clk_i); #1;
        apb_penable_i = 1'b1;
        #2 arst_i = 1'b1;
        @(negedge clk_i);
        total++; if (apb_pready_o !== 1'b0 || roi_en_o !== 4'h0 || roi_xy0_o !== '0) $display("FAIL rst_mid: pready=%b en=%b xy0=%h want 0", apb_pready_o, roi_en_o, roi_xy0_o); else passed++;
        apb_psel_i = 1'b0; apb_penable_i = 1'b0;
        @(posedge clk_i); #1 arst_i = 1'b0;
        apb_xfer(12'h100, 1'b0, 32'h0, 1'b0, rd, err, lat);
        total++; if (rd !== 32'h0 || err !== 1'b0) $display("FAIL rst_mid_ctrl: got %h/%b want 0/0", rd, err); else passed++;
        apb_xfer(12'h030, 1'b0, 32'h0, 1'b0, rd, err, lat);
        total++; if (rd !== 32'h0) $display("FAIL rst_mid_xy: got %h want 0", rd); else passed++;
    endtask

    initial begin
        test_reset();
`ifdef ROI_SHADOW_EN
        test_commit();
        test_commit_collision();
        test_invalid();
`else
        test_direct();
`endif
        test_errors();
        test_back_to_back();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, passed=%0d total=%0d", passed, total);
        $fatal(1);
    end

endmodule

// File: doc/roi_apb_regfile.md
# roi_apb_regfile

Multi-channel ROI configuration slave on the APB bus. Supersedes the single-ROI write-only register with a full APB3 handshake, read-back, error response, per-ROI enables and double-buffered (shadow/active) coordinates committed at frame boundaries. It feeds the ROI crop/statistics datapath with stable, validated rectangles.

## Interface
- APB_DATA_WIDTH, 32, PWDATA/PRDATA width; fixed at 32 for this revision.
- APB_ADDR_WIDTH, 12, byte address width; the slave occupies a 4 KB window.
- NUM_ROI, 4, number of ROI channels; legal range 1..16.
- COORD_WIDTH, 16, width of each x/y coordinate; fixed at 16 for this revision.
- Reset is arst_i, asynchronous, active-high; the clock is clk_i.
- clk_i  in  1  clock
- arst_i  in  1  async reset, active-high
- apb_psel_i  in  1  slave select
- apb_penable_i  in  1  access phase
- apb_pwrite_i  in  1  1 = write, 0 = read
- apb_paddr_i  in  APB_ADDR_WIDTH  byte address
- apb_pwdata_i  in  32  write data
- apb_prdata_o  out  32  read data; valid while pready=1
- apb_pready_o  out  1  transfer complete
- apb_pslverr_o  out  1  error response; valid while pready=1
- frame_start_i  in  1  single-cycle frame boundary strobe
- roi_xy0_o  out  NUM_ROI*32  active top-left corners; ROI i occupies bits [32i+31:32i] as {y0,x0}
- roi_xy1_o  out  NUM_ROI*32  active bottom-right corners as {y1,x1}
- roi_en_o  out  NUM_ROI  active per-ROI enable
- commit_done_o  out  1  one-cycle pulse when shadow is copied to active

## Operation
- Register map (byte offsets):
  - 0x10*i+0x0: XY0_i {y0[31:16], x0[15:0]}, RW.
  - 0x10*i+0x4: XY1_i {y1, x1}, RW.
  - 0x100: CTRL; bits [NUM_ROI-1:0] are the shadow enables, RW.
  - 0x104: STATUS; bit0 pending (RO), bit1 err (sticky, W1C), bits [16+NUM_ROI-1:16] invalid-ROI flags (sticky, W1C).
  - 0x108: COMMIT; writing bit0=1 sets pending. Reads as 0.
- Register reads return the shadow copies. Unused bits read as 0.
- The following each complete with pslverr=1, return prdata=0 and write nothing:
  - unmapped address;
  - paddr[1:0]≠0;
  - ROI index ≥ NUM_ROI;
  - write to STATUS bits other than W1C bits. This case still performs the W1C action.
- APB FSM states:
  - IDLE: moves to RESP when psel & penable.
  - RESP: pready=1 with registered prdata/pslverr. The write is applied on the edge leaving RESP. Then returns to IDLE.
  - psel&!penable (setup phase) keeps the FSM in IDLE.
- Commit: on frame_start_i with pending=1, for each ROI i:
  - If x0≤x1 and y0≤y1 (unsigned): copy XY0/XY1/en from shadow to active.
  - Otherwise: active en_i is forced to 0, active coordinates are held, flag i and err are set.
  - Pending clears and commit_done_o pulses on the following cycle.
- Simultaneous events:
  - A COMMIT write applied in the same cycle as frame_start_i sets pending only; the copy happens at the next frame_start_i.
  - A shadow write in the same cycle as a commit copy is not included; the old shadow value is copied.
  - frame_start_i with pending=0 has no effect.
- Reset mid-transfer aborts the access and clears all state.

## Timing
- Reset values: all outputs 0, FSM in IDLE, all shadow, active and status registers 0.
- Every access costs exactly one wait state: setup at T, penable at T+1, pready at T+2. Back-to-back accesses are supported.
- Active outputs change on the clock edge after the frame_start_i sample (1-cycle latency). commit_done_o is high in the same cycle the new active values appear.
- Active outputs are registers and are glitch-free between commits.

## Configuration
- ROI_SHADOW_EN defined: double buffering and validation as described above.
- ROI_SHADOW_EN undefined:
  - Writes update the active registers directly on the RESP edge; reads return active.
  - COMMIT writes are accepted with pslverr=0 but ignored; pending reads 0.
  - frame_start_i is ignored and commit_done_o is tied 0.
  - No validation; the invalid flags and err stay 0.

## Structure
- Package roi_pkg holds:
  - register offset localparams;
  - typedef roi_pt_t struct packed {y, x};
  - typedef roi_rect_t {xy0, xy1, en};
  - the APB state enum {IDLE, RESP}.
- Sub-module roi_bank: shadow and active storage, validation and commit for one ROI. It is instantiated NUM_ROI times via generate. The top level keeps the APB FSM, decode, and the status/pending logic.

## Test plan
- Reset -> all outputs 0. Read 0x104 -> prdata 0, pslverr 0, pready at T+2.
- Write XY0_1=0x0010_0020, XY1_1=0x0040_0080, CTRL=0x2, COMMIT=1, then pulse frame_start_i:
  - roi_xy0_o[63:32]=0x00100020 and roi_en_o=4'b0010 one cycle later, with commit_done_o=1.
  - Before commit, read-back of XY0_1 returns 0x00100020 and active is still 0.
- Invalid ROI: XY0_0=0x0000_0100, XY1_0=0x0000_0010, en=1, commit:
  - roi_en_o[0]=0 and STATUS=0x0001_0002.
  - Writing 0x0001_0002 to STATUS clears it to 0.
- Read 0x0FC and 0x002, and with NUM_ROI=4 write 0x040 -> pslverr=1, prdata=0, no state change.
- COMMIT write completing in the same cycle as frame_start_i -> no copy; the copy happens at the next frame_start_i.
- Build without ROI_SHADOW_EN: write XY1_2=0x1234_5678 -> roi_xy1_o[95:64]=0x12345678 after the RESP edge; frame_start_i has no effect.
